// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte-frame to 8-bit register bus command bridge (UART_BRIDGE_CHECKSUM_EN adds XOR checksum byte)
module uart_cmd_bridge #(
   parameter int unsigned TIMEOUT = 500_000,
   parameter int unsigned TO_BIT  = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_we,
   output logic       bus_re,
   input  logic [7:0] bus_rdata,
   output logic       busy,
   output logic       frame_err
);

   localparam logic [7:0] CMD_WR     = 8'h57;
   localparam logic [7:0] CMD_RD     = 8'h52;
   localparam logic [7:0] RPL_ACK    = 8'h4B;
   localparam logic [7:0] RPL_BADCMD = 8'h3F;
   localparam logic [7:0] RPL_BADCHK = 8'h21;
   localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
      S_GET_CHK,
`endif
      S_EXEC,
      S_RD_WAIT,
      S_SEND
   } state_t;

   state_t            state_q, state_d;
   logic              is_wr_q, is_wr_d;
   logic [7:0]        addr_stage_q, addr_stage_d;
   logic [7:0]        data_stage_q, data_stage_d;
   logic [7:0]        bus_addr_q, bus_addr_d;
   logic [7:0]        bus_wdata_q, bus_wdata_d;
   logic [7:0]        reply_q, reply_d;
   logic [TO_BIT-1:0] cnt_q, cnt_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
`endif

   logic pop;
   logic in_get;
   logic last_byte;
   logic go_exec;

   // State and datapath registers; reset drops any frame in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         is_wr_q      <= 1'b0;
         addr_stage_q <= '0;
         data_stage_q <= '0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         reply_q      <= '0;
         cnt_q        <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
         chk_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         is_wr_q      <= is_wr_d;
         addr_stage_q <= addr_stage_d;
         data_stage_q <= data_stage_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         reply_q      <= reply_d;
         cnt_q        <= cnt_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
         chk_q        <= chk_d;
`endif
      end
   end

   // Frame decode, inter-byte timeout, bus strobes and reply hand-off
   always_comb begin
      state_d      = state_q;
      is_wr_d      = is_wr_q;
      addr_stage_d = addr_stage_q;
      data_stage_d = data_stage_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      reply_d      = reply_q;
      cnt_d        = '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      chk_d        = chk_q;
`endif
      pop       = 1'b0;
      last_byte = 1'b0;
      go_exec   = 1'b0;
      wr_uart   = 1'b0;
      bus_we    = 1'b0;
      bus_re    = 1'b0;
      frame_err = 1'b0;

      in_get = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA)
`ifdef UART_BRIDGE_CHECKSUM_EN
               || (state_q == S_GET_CHK)
`endif
               ;

      // Mid-frame: a byte wins over an expiring counter; counter clears on pop
      if (in_get) begin
         if (!rx_empty) begin
            pop = 1'b1;
         end else if (cnt_q == TO_LAST) begin
            frame_err = 1'b1;
            state_d   = S_IDLE;
         end else begin
            cnt_d = cnt_q + TO_BIT'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            // Nothing is accepted while reset is held so outputs stay quiet
            if (!rx_empty && !reset) begin
               pop     = 1'b1;
               is_wr_d = (r_data == CMD_WR);
               if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
                  state_d = S_GET_ADDR;
               end else begin
                  reply_d   = RPL_BADCMD;
                  frame_err = 1'b1;
                  state_d   = S_SEND;
               end
            end
         end
         S_GET_ADDR: begin
            if (pop) begin
               addr_stage_d = r_data;
               if (is_wr_q) begin
                  state_d = S_GET_DATA;
               end else begin
                  last_byte = 1'b1;
               end
            end
         end
         S_GET_DATA: begin
            if (pop) begin
               data_stage_d = r_data;
               last_byte    = 1'b1;
            end
         end
`ifdef UART_BRIDGE_CHECKSUM_EN
         S_GET_CHK: begin
            if (pop) begin
               if ((chk_q ^ r_data) == 8'h00) begin
                  go_exec = 1'b1;
               end else begin
                  reply_d   = RPL_BADCHK;
                  frame_err = 1'b1;
                  state_d   = S_SEND;
               end
            end
         end
`endif
         S_EXEC: begin
            if (is_wr_q) begin
               bus_we  = 1'b1;
               reply_d = RPL_ACK;
               state_d = S_SEND;
            end else begin
               bus_re  = 1'b1;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            reply_d = bus_rdata;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (!tx_full) begin
               wr_uart = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef UART_BRIDGE_CHECKSUM_EN
      // Running XOR of every frame byte before the check byte
      if (pop) begin
         chk_d = (state_q == S_IDLE) ? r_data : (chk_q ^ r_data);
      end
      if (last_byte) begin
         state_d = S_GET_CHK;
      end
`else
      if (last_byte) begin
         go_exec = 1'b1;
      end
`endif

      // Bus address/data only change for a frame that will really execute
      if (go_exec) begin
         state_d    = S_EXEC;
         bus_addr_d = addr_stage_d;
         if (is_wr_q) begin
            bus_wdata_d = data_stage_d;
         end
      end
   end

   assign rd_uart   = pop;
   assign w_data    = reply_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - self-checking bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

   localparam int TO = 40;
`ifdef UART_BRIDGE_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic       tx_full;
   logic       wr_uart;
   logic [7:0] w_data;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic       busy;
   logic       frame_err;

   always #5 clk = ~clk;

   uart_cmd_bridge #(.TIMEOUT(TO), .TO_BIT(8)) dut (
      .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
      .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .busy(busy), .frame_err(frame_err)
   );

   // RX FIFO: stimulus bytes written by the main sequence, head index moved by pops
   logic [7:0] stim [4096];
   int push_n = 0;
   int pop_n  = 0;
   assign rx_empty = (pop_n == push_n);
   assign r_data   = stim[pop_n[11:0]];
   always @(posedge clk) if (rd_uart) pop_n <= pop_n + 1;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event logs sampled just after the falling edge
   int n_tx = 0, n_we = 0, n_re = 0, n_ferr = 0, n_pop = 0, viol = 0;
   logic [7:0]  tx_log [1024];
   int          tx_cyc [1024];
   logic [15:0] we_log [1024];
   int          we_cyc [1024];
   logic [7:0]  re_log [1024];
   int          re_cyc [1024];
   int          fe_cyc [1024];
   int          pop_cyc [4096];
   always @(negedge clk) begin
      #1;
      if (wr_uart) begin
         tx_log[n_tx[9:0]] = w_data; tx_cyc[n_tx[9:0]] = cyc; n_tx++;
         if (tx_full) viol++;
      end
      if (bus_we) begin
         we_log[n_we[9:0]] = {bus_addr, bus_wdata}; we_cyc[n_we[9:0]] = cyc; n_we++;
      end
      if (bus_re) begin
         re_log[n_re[9:0]] = bus_addr; re_cyc[n_re[9:0]] = cyc; n_re++;
      end
      if (frame_err) begin
         fe_cyc[n_ferr[9:0]] = cyc; n_ferr++;
      end
      if (rd_uart) begin
         pop_cyc[n_pop[11:0]] = cyc; n_pop++;
         if (rx_empty) viol++;
      end
   end

   // Peripheral register file; read data appears the cycle after bus_re, junk otherwise
   logic [7:0] periph [256] = '{default: 8'h00};
   logic       re_prev = 1'b0;
   always @(negedge clk) begin
      if (bus_we) periph[bus_addr] <= bus_wdata;
      if (bus_re) bus_rdata <= periph[bus_addr];
      else if (!re_prev) bus_rdata <= 8'($urandom);
      re_prev <= bus_re;
   end

   // Reference model: what the register file must contain after each accepted write
   logic [7:0] model_mem [256] = '{default: 8'h00};

   int n_pass = 0, n_fail = 0, n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      stim[push_n[11:0]] = b;
      push_n++;
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      logic done = 1'b0;
      while (guard < 150 && !done) begin
         @(negedge clk);
         guard++;
         done = (pop_n == push_n) && !busy;
      end
      check({tag, "_done"}, done, 1);
   endtask

   // Sends one frame (checksum appended when enabled) and checks the outcome against the model
   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int hold, input logic [7:0] chk_flip, input string tag);
      logic [7:0] frm [4];
      int nb, exp_we, exp_re, exp_err, lat, guard;
      int tx0, we0, re0, fe0;
      logic [7:0] exp_reply;
      logic is_wr, is_rd;
      tx0 = n_tx; we0 = n_we; re0 = n_re; fe0 = n_ferr;
      is_wr = (b0 == 8'h57);
      is_rd = (b0 == 8'h52);
      frm[0] = b0; frm[1] = b1; frm[2] = b2; frm[3] = 8'h00;
      nb = is_wr ? 3 : (is_rd ? 2 : 1);
      if (CHK_EN && (is_wr || is_rd)) begin
         frm[nb] = (is_wr ? (b0 ^ b1 ^ b2) : (b0 ^ b1)) ^ chk_flip;
         nb++;
      end
      exp_we = 0; exp_re = 0; exp_err = 0;
      if (!is_wr && !is_rd) begin
         exp_reply = 8'h3F; exp_err = 1; lat = 1;
      end else if (CHK_EN && chk_flip != 8'h00) begin
         exp_reply = 8'h21; exp_err = 1; lat = 1;
      end else if (is_wr) begin
         exp_reply = 8'h4B; exp_we = 1; lat = 2;
         model_mem[b1] = b2;
      end else begin
         exp_reply = model_mem[b1]; exp_re = 1; lat = 3;
      end
      tx_full = (hold > 0);
      for (int i = 0; i < nb; i++) begin
         push_byte(frm[i]);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (hold > 0) begin
         guard = 0;
         while (pop_n != push_n && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         repeat (hold) @(negedge clk);
         check({tag, "_held"}, n_tx - tx0, 0);
         check({tag, "_busy_held"}, busy, 1);
         tx_full = 1'b0;
      end
      wait_idle(tag);
      check({tag, "_ntx"}, n_tx - tx0, 1);
      if (n_tx > tx0) check({tag, "_reply"}, tx_log[tx0[9:0]], exp_reply);
      check({tag, "_nwe"}, n_we - we0, exp_we);
      check({tag, "_nre"}, n_re - re0, exp_re);
      check({tag, "_nerr"}, n_ferr - fe0, exp_err);
      if (exp_we != 0 && n_we > we0) begin
         check({tag, "_we_addr_data"}, we_log[we0[9:0]], {b1, b2});
         check({tag, "_we_lat"}, we_cyc[we0[9:0]] - pop_cyc[(n_pop - 1) % 4096], 1);
      end
      if (exp_re != 0 && n_re > re0) begin
         check({tag, "_re_addr"}, re_log[re0[9:0]], b1);
         check({tag, "_re_lat"}, re_cyc[re0[9:0]] - pop_cyc[(n_pop - 1) % 4096], 1);
      end
      if (hold == 0 && n_tx > tx0)
         check({tag, "_tx_lat"}, tx_cyc[tx0[9:0]] - pop_cyc[(n_pop - 1) % 4096], lat);
   endtask

   initial begin
      int tx0, we0, fe0, p0, guard, la;
      logic [7:0] a, d, b, flip;
      int kind;

      reset = 1'b1;
      tx_full = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctrl", {26'd0, busy, rd_uart, wr_uart, bus_we, bus_re, frame_err}, 0);
      check("rst_w_data", w_data, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      run_frame(8'h57, 8'h10, 8'hA5, 0, 8'h00, "t1_wr");
      run_frame(8'h57, 8'h22, 8'h3C, 0, 8'h00, "t2_wr");
      run_frame(8'h52, 8'h22, 8'h00, 0, 8'h00, "t2_rd");
      run_frame(8'h41, 8'h00, 8'h00, 0, 8'h00, "t3_badcmd");
      check("t3_busy_after", busy, 0);

      // Inter-byte timeout: frame abandoned with no reply and no bus access
      tx0 = n_tx; we0 = n_we; fe0 = n_ferr;
      push_byte(8'h57);
      push_byte(8'h10);
      guard = 0;
      while (pop_n != push_n && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      repeat (TO + 5) @(negedge clk);
      check("t4_nerr", n_ferr - fe0, 1);
      check("t4_nwe", n_we - we0, 0);
      check("t4_ntx", n_tx - tx0, 0);
      check("t4_busy", busy, 0);
      if (n_ferr > fe0) check("t4_to_cycles", fe_cyc[fe0[9:0]] - pop_cyc[(n_pop - 1) % 4096], TO);
      run_frame(8'h52, 8'h10, 8'h00, 0, 8'h00, "t4_after");

      run_frame(8'h57, 8'h30, 8'h77, 20, 8'h00, "t5_hold");

`ifdef UART_BRIDGE_CHECKSUM_EN
      run_frame(8'h57, 8'h10, 8'hA5, 0, 8'h00, "t6_chk_ok");
      run_frame(8'h57, 8'h10, 8'hA5, 0, 8'hE2, "t6_chk_bad");
      run_frame(8'h52, 8'h10, 8'h00, 0, 8'h00, "t6_rd");
`endif

      // Back-to-back write then read, all bytes queued at once
      tx0 = n_tx; p0 = n_pop;
      a = 8'h44; d = 8'h9E;
      push_byte(8'h57); push_byte(a); push_byte(d);
      if (CHK_EN) push_byte(8'h57 ^ a ^ d);
      push_byte(8'h52); push_byte(a);
      if (CHK_EN) push_byte(8'h52 ^ a);
      model_mem[a] = d;
      la = CHK_EN ? 4 : 3;
      wait_idle("b2b");
      check("b2b_ntx", n_tx - tx0, 2);
      if (n_tx >= tx0 + 2) begin
         check("b2b_reply0", tx_log[tx0[9:0]], 8'h4B);
         check("b2b_reply1", tx_log[(tx0 + 1) % 1024], model_mem[a]);
      end
      if (n_pop > p0 + la) check("b2b_no_dead", pop_cyc[(p0 + la) % 4096] - tx_cyc[tx0[9:0]], 1);

      // Reset mid-frame drops the frame silently
      tx0 = n_tx; we0 = n_we;
      push_byte(8'h57); push_byte(8'h33);
      guard = 0;
      while (pop_n != push_n && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("mrst_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("mrst_busy", busy, 0);
      check("mrst_ntx", n_tx - tx0, 0);
      check("mrst_nwe", n_we - we0, 0);
      check("mrst_bus_addr", bus_addr, 0);

      // Randomised frames against the model
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         a = 8'($urandom_range(0, 7));
         d = 8'($urandom);
         flip = 8'h00;
         if (kind <= 3) begin
            run_frame(8'h57, a, d, 0, flip, "rnd_wr");
         end else if (kind <= 7) begin
            run_frame(8'h52, a, 8'h00, 0, flip, "rnd_rd");
         end else if (kind == 8) begin
            b = 8'($urandom);
            while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
            run_frame(b, 8'h00, 8'h00, 0, flip, "rnd_bad");
         end else begin
            flip = CHK_EN ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(8'h57, a, d, 0, flip, "rnd_chk");
         end
      end

      check("protocol_viol", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
